reservation_station: RTL and testbench
======================================

Name: reservation_station

Overview:
- Consumer end of the instruction-queue interface. Accepts one decoded instruction per cycle: opcode, RX, RY, RZ, immediate.
- Drives `stall` back to the queue when no entry is free.
- Holds instructions in Tomasulo-style entries until their operands are ready, and renames destinations through an external register status unit.
- Snoops the common data bus (CDB) and dispatches ready entries to the functional unit over a valid/ready handshake.

Parameters:
- NUM_ENTRIES, 3, number of entries; tag of entry i = i+1, tag 0 = "no producer"
- TAG_W, 2, tag width; must satisfy 2^TAG_W > NUM_ENTRIES
- DATA_W, 16, operand/result width

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- opcode  in  3  000 ADD, 001 SUB, 010 LD, 011 SD, 111 bubble, others reserved (treated as bubble)
- RX  in  3  destination register; data source register for SD
- RY  in  3  source A / base register
- RZ  in  3  source B for ADD/SUB
- immediate  in  4  zero-extended offset for LD/SD
- stall  out  1  1 = full, the queue must hold its current instruction
- rd_addr_a  out  3  combinational = RY
- rd_addr_b  out  3  combinational = RX if opcode==SD, else RZ
- rd_data_a, rd_data_b  in  DATA_W  register values
- rd_busy_a, rd_busy_b  in  1  register awaiting a producer
- rd_tag_a, rd_tag_b  in  TAG_W  producer tag when busy
- rename_we  out  1  combinational; 1 on accept of ADD/SUB/LD
- rename_reg  out  3  = RX
- rename_tag  out  TAG_W  allocated tag
- cdb_valid  in  1  result broadcast valid
- cdb_tag  in  TAG_W  producer tag of broadcast
- cdb_data  in  DATA_W  result value
- fu_valid  out  1  dispatch valid, registered
- fu_ready  in  1  functional unit accepts
- fu_opcode  out  3
- fu_a, fu_b  out  DATA_W  operand values
- fu_imm  out  4
- fu_tag  out  TAG_W  tag of the dispatched entry

Behaviour:
- Entry fields: busy, issued, op, Vj, Vk, Qj, Qk, imm.
- Reset (async, any time, including mid-dispatch):
  - All entries not busy; stall=0.
  - fu_valid=0; fu_opcode, fu_a, fu_b, fu_imm, fu_tag all 0.
  - rename_we=0 while reset is high.
- stall: = all entries busy, derived from registered state only. An entry freed at the same edge does not lower stall until the next cycle.
- Accept:
  - Occurs at a rising edge when stall==0 and opcode is not bubble/reserved. The queue advances at the same edge.
  - The instruction is written into the lowest-index free entry; busy=1, issued=0.
- Operand capture at accept, per operand:
  - If rd_busy=0: V=rd_data, Q=0.
  - Else if cdb_valid and cdb_tag==rd_tag: V=cdb_data, Q=0 (same-cycle bypass).
  - Else: Q=rd_tag.
- Operand usage by opcode:
  - LD ignores operand b: Vk=0, Qk=0.
  - SD: Vk=value of RX; no rename.
- rename_we is asserted only in the accept cycle, combinationally with it. Register 0 is renamed like any other register.
- CDB snoop, every edge with cdb_valid=1:
  - Every busy entry with Qj==cdb_tag takes Vj=cdb_data, Qj=0; same for Qk.
  - The entry whose own tag==cdb_tag clears busy, freeing it.
  - cdb_tag==0 is ignored.
- Ready: busy && !issued && Qj==0 && Qk==0, evaluated on registered state. An operand captured at edge t makes the entry ready from cycle t+1.
- Dispatch:
  - When fu_valid==0 or fu_ready==1 at an edge, the output register loads the selected ready entry: fu_valid=1, fields copied, entry issued=1.
  - If no entry is ready, fu_valid=0.
  - fu_valid with its fields is held stable while fu_ready==0.
- Selection: lowest-index ready entry, unless the optional feature is enabled.
- Entry lifetime: allocate -> wait -> issued -> freed on its own CDB tag. A tag is never reused before its broadcast.
- Simultaneous accept and free at the same edge are both performed; the accept uses only entries free before the edge.

Optional Feature:
- Macro: RS_OLDEST_FIRST_EN.
- Defined:
  - Each entry has a saturating age counter of TAG_W+1 bits.
  - Age is set to 0 on allocation and incremented on every accept while busy.
  - Dispatch picks the ready entry with the highest age; ties go to the lowest index.
- Undefined: lowest-index selection; no age state.

Test Plan:
- Reset, then ADD R0,R1,R2 with rd_busy=0, rd_data_a=5, rd_data_b=7, fu_ready=1 -> rename_we=1, rename_tag=1 in the accept cycle; one cycle later fu_valid=1, fu_opcode=000, fu_a=5, fu_b=7, fu_tag=1.
- Three accepts with fu_ready=0 -> stall=1 after the third edge; a fourth instruction is held. cdb_valid with cdb_tag=1 -> stall=0 the next cycle, and the held instruction takes entry 1 (tag 1).
- SUB with rd_busy_a=1, rd_tag_a=2 -> not dispatched; cdb_tag=2, cdb_data=16'h00AA -> fu_a=16'h00AA, fu_valid=1 one cycle after capture.
- Accept with rd_busy_b=1, rd_tag_b=3 while cdb_valid=1, cdb_tag=3, cdb_data=9 in the same cycle -> Vk=9, dispatch next cycle (bypass).
- fu_ready=0 with fu_valid=1 for 3 cycles -> outputs unchanged; assert reset mid-hold -> fu_valid=0 and stall=0 immediately, without waiting for a clock edge.
- RS_OLDEST_FIRST_EN: fill entries 2 then 1, make both ready in the same cycle -> entry 2 (tag 2) dispatched first; without the macro -> tag 1 first.

Source files
------------

// File: rtl/reservation_station.sv
// Tomasulo reservation station: accepts decoded instructions, renames destinations, snoops the CDB and
// dispatches ready entries to the functional unit. Define RS_OLDEST_FIRST_EN for age-based dispatch.

module rs_entry #(
  parameter int               TAG_W  = 2,
  parameter int               DATA_W = 16,
  parameter logic [TAG_W-1:0] MY_TAG = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alloc,
  input  logic [2:0]        a_op,
  input  logic [DATA_W-1:0] a_vj,
  input  logic [DATA_W-1:0] a_vk,
  input  logic [TAG_W-1:0]  a_qj,
  input  logic [TAG_W-1:0]  a_qk,
  input  logic [3:0]        a_imm,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              issue,
`ifdef RS_OLDEST_FIRST_EN
  input  logic              age_inc,
  output logic [TAG_W:0]    age,
`endif
  output logic              busy,
  output logic              ready,
  output logic [2:0]        op,
  output logic [DATA_W-1:0] vj,
  output logic [DATA_W-1:0] vk,
  output logic [3:0]        imm
);
  logic              busy_q, busy_d, issued_q, issued_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] vj_q, vj_d, vk_q, vk_d;
  logic [TAG_W-1:0]  qj_q, qj_d, qk_q, qk_d;
  logic [3:0]        imm_q, imm_d;
  logic              cdb_hit;

  assign cdb_hit = cdb_valid && (cdb_tag != '0);

  always_comb begin
    busy_d   = busy_q;
    issued_d = issued_q;
    op_d     = op_q;
    vj_d     = vj_q;
    vk_d     = vk_q;
    qj_d     = qj_q;
    qk_d     = qk_q;
    imm_d    = imm_q;
    if (alloc) begin
      busy_d   = 1'b1;
      issued_d = 1'b0;
      op_d     = a_op;
      vj_d     = a_vj;
      vk_d     = a_vk;
      qj_d     = a_qj;
      qk_d     = a_qk;
      imm_d    = a_imm;
    end else if (busy_q) begin
      if (issue) issued_d = 1'b1;
      if (cdb_hit && qj_q == cdb_tag) begin
        vj_d = cdb_data;
        qj_d = '0;
      end
      if (cdb_hit && qk_q == cdb_tag) begin
        vk_d = cdb_data;
        qk_d = '0;
      end
      // our own result on the bus retires the entry
      if (cdb_hit && cdb_tag == MY_TAG) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q   <= 1'b0;
      issued_q <= 1'b0;
      op_q     <= '0;
      vj_q     <= '0;
      vk_q     <= '0;
      qj_q     <= '0;
      qk_q     <= '0;
      imm_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      issued_q <= issued_d;
      op_q     <= op_d;
      vj_q     <= vj_d;
      vk_q     <= vk_d;
      qj_q     <= qj_d;
      qk_q     <= qk_d;
      imm_q    <= imm_d;
    end
  end

`ifdef RS_OLDEST_FIRST_EN
  logic [TAG_W:0] age_q, age_d;

  always_comb begin
    age_d = age_q;
    if (alloc)                                  age_d = '0;
    else if (busy_q && age_inc && age_q != '1)  age_d = age_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) age_q <= '0;
    else       age_q <= age_d;
  end

  assign age = age_q;
`endif

  assign busy  = busy_q;
  assign ready = busy_q && !issued_q && (qj_q == '0) && (qk_q == '0);
  assign op    = op_q;
  assign vj    = vj_q;
  assign vk    = vk_q;
  assign imm   = imm_q;
endmodule

module reservation_station #(
  parameter int NUM_ENTRIES = 3,
  parameter int TAG_W       = 2,
  parameter int DATA_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        opcode,
  input  logic [2:0]        RX,
  input  logic [2:0]        RY,
  input  logic [2:0]        RZ,
  input  logic [3:0]        immediate,
  output logic              stall,
  output logic [2:0]        rd_addr_a,
  output logic [2:0]        rd_addr_b,
  input  logic [DATA_W-1:0] rd_data_a,
  input  logic [DATA_W-1:0] rd_data_b,
  input  logic              rd_busy_a,
  input  logic              rd_busy_b,
  input  logic [TAG_W-1:0]  rd_tag_a,
  input  logic [TAG_W-1:0]  rd_tag_b,
  output logic              rename_we,
  output logic [2:0]        rename_reg,
  output logic [TAG_W-1:0]  rename_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              fu_valid,
  input  logic              fu_ready,
  output logic [2:0]        fu_opcode,
  output logic [DATA_W-1:0] fu_a,
  output logic [DATA_W-1:0] fu_b,
  output logic [3:0]        fu_imm,
  output logic [TAG_W-1:0]  fu_tag
);
  localparam logic [2:0] OP_LD = 3'b010;
  localparam logic [2:0] OP_SD = 3'b011;

  logic [NUM_ENTRIES-1:0]             e_busy, e_ready, e_alloc, e_issue;
  logic [NUM_ENTRIES-1:0][2:0]        e_op;
  logic [NUM_ENTRIES-1:0][DATA_W-1:0] e_vj, e_vk;
  logic [NUM_ENTRIES-1:0][3:0]        e_imm;
`ifdef RS_OLDEST_FIRST_EN
  logic [NUM_ENTRIES-1:0][TAG_W:0]    e_age;
  logic [TAG_W:0]                     sel_age;
`endif

  logic              accept, fu_load, sel_found;
  logic [TAG_W-1:0]  alloc_tag, sel_tag;
  logic [DATA_W-1:0] opa_v, opb_v, sel_a, sel_b;
  logic [TAG_W-1:0]  opa_q, opb_q;
  logic [2:0]        sel_op;
  logic [3:0]        sel_imm;

  // stall only looks at registered busy bits, so a same-edge free is seen a cycle later
  assign stall      = &e_busy;
  assign accept     = !stall && !opcode[2];
  assign rd_addr_a  = RY;
  assign rd_addr_b  = (opcode == OP_SD) ? RX : RZ;
  assign rename_we  = accept && !reset && (opcode != OP_SD);
  assign rename_reg = RX;
  assign rename_tag = alloc_tag;

  always_comb begin
    alloc_tag = '0;
    for (int i = NUM_ENTRIES-1; i >= 0; i--)
      if (!e_busy[i]) alloc_tag = TAG_W'(i+1);
  end

  always_comb begin
    if (!rd_busy_a) begin
      opa_v = rd_data_a; opa_q = '0;
    end else if (cdb_valid && cdb_tag != '0 && cdb_tag == rd_tag_a) begin
      opa_v = cdb_data;  opa_q = '0;
    end else begin
      opa_v = '0;        opa_q = rd_tag_a;
    end
    if (opcode == OP_LD) begin
      opb_v = '0;        opb_q = '0;
    end else if (!rd_busy_b) begin
      opb_v = rd_data_b; opb_q = '0;
    end else if (cdb_valid && cdb_tag != '0 && cdb_tag == rd_tag_b) begin
      opb_v = cdb_data;  opb_q = '0;
    end else begin
      opb_v = '0;        opb_q = rd_tag_b;
    end
  end

  always_comb begin
    sel_found = 1'b0;
    sel_tag   = '0;
    sel_op    = '0;
    sel_a     = '0;
    sel_b     = '0;
    sel_imm   = '0;
`ifdef RS_OLDEST_FIRST_EN
    sel_age   = '0;
    // strict compare keeps the lowest index on equal ages
    for (int i = 0; i < NUM_ENTRIES; i++)
      if (e_ready[i] && (!sel_found || e_age[i] > sel_age)) begin
        sel_found = 1'b1;
        sel_age   = e_age[i];
        sel_tag   = TAG_W'(i+1);
        sel_op    = e_op[i];
        sel_a     = e_vj[i];
        sel_b     = e_vk[i];
        sel_imm   = e_imm[i];
      end
`else
    for (int i = NUM_ENTRIES-1; i >= 0; i--)
      if (e_ready[i]) begin
        sel_found = 1'b1;
        sel_tag   = TAG_W'(i+1);
        sel_op    = e_op[i];
        sel_a     = e_vj[i];
        sel_b     = e_vk[i];
        sel_imm   = e_imm[i];
      end
`endif
  end

  assign fu_load = !fu_valid || fu_ready;

  always_comb begin
    e_alloc = '0;
    e_issue = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      e_alloc[i] = accept && (alloc_tag == TAG_W'(i+1));
      e_issue[i] = fu_load && sel_found && (sel_tag == TAG_W'(i+1));
    end
  end

  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_ent
    rs_entry #(.TAG_W(TAG_W), .DATA_W(DATA_W), .MY_TAG(TAG_W'(g+1))) u_ent (
      .clock     (clock),
      .reset     (reset),
      .alloc     (e_alloc[g]),
      .a_op      (opcode),
      .a_vj      (opa_v),
      .a_vk      (opb_v),
      .a_qj      (opa_q),
      .a_qk      (opb_q),
      .a_imm     (immediate),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .issue     (e_issue[g]),
`ifdef RS_OLDEST_FIRST_EN
      .age_inc   (accept),
      .age       (e_age[g]),
`endif
      .busy      (e_busy[g]),
      .ready     (e_ready[g]),
      .op        (e_op[g]),
      .vj        (e_vj[g]),
      .vk        (e_vk[g]),
      .imm       (e_imm[g])
    );
  end

  logic              fu_valid_q, fu_valid_d;
  logic [2:0]        fu_opcode_q, fu_opcode_d;
  logic [DATA_W-1:0] fu_a_q, fu_a_d, fu_b_q, fu_b_d;
  logic [3:0]        fu_imm_q, fu_imm_d;
  logic [TAG_W-1:0]  fu_tag_q, fu_tag_d;

  always_comb begin
    fu_valid_d  = fu_valid_q;
    fu_opcode_d = fu_opcode_q;
    fu_a_d      = fu_a_q;
    fu_b_d      = fu_b_q;
    fu_imm_d    = fu_imm_q;
    fu_tag_d    = fu_tag_q;
    if (fu_load) begin
      fu_valid_d = sel_found;
      if (sel_found) begin
        fu_opcode_d = sel_op;
        fu_a_d      = sel_a;
        fu_b_d      = sel_b;
        fu_imm_d    = sel_imm;
        fu_tag_d    = sel_tag;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fu_valid_q  <= 1'b0;
      fu_opcode_q <= '0;
      fu_a_q      <= '0;
      fu_b_q      <= '0;
      fu_imm_q    <= '0;
      fu_tag_q    <= '0;
    end else begin
      fu_valid_q  <= fu_valid_d;
      fu_opcode_q <= fu_opcode_d;
      fu_a_q      <= fu_a_d;
      fu_b_q      <= fu_b_d;
      fu_imm_q    <= fu_imm_d;
      fu_tag_q    <= fu_tag_d;
    end
  end

  assign fu_valid  = fu_valid_q;
  assign fu_opcode = fu_opcode_q;
  assign fu_a      = fu_a_q;
  assign fu_b      = fu_b_q;
  assign fu_imm    = fu_imm_q;
  assign fu_tag    = fu_tag_q;
endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed scenarios plus randomized traffic against an entry-table model.
module tb_reservation_station;
  localparam int N = 3, TW = 2, DW = 16;
`ifdef RS_OLDEST_FIRST_EN
  localparam bit OLDEST = 1'b1;
`else
  localparam bit OLDEST = 1'b0;
`endif

  logic clock = 1'b0, reset;
  logic [2:0] opcode, RX, RY, RZ, rd_addr_a, rd_addr_b, rename_reg, fu_opcode;
  logic [3:0] immediate, fu_imm;
  logic stall, rd_busy_a, rd_busy_b, rename_we, cdb_valid, fu_valid, fu_ready;
  logic [DW-1:0] rd_data_a, rd_data_b, cdb_data, fu_a, fu_b;
  logic [TW-1:0] rd_tag_a, rd_tag_b, rename_tag, cdb_tag, fu_tag;
  int checks = 0, failures = 0;

  reservation_station #(.NUM_ENTRIES(N), .TAG_W(TW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .RX(RX), .RY(RY), .RZ(RZ), .immediate(immediate),
    .stall(stall), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a),
    .rd_data_b(rd_data_b), .rd_busy_a(rd_busy_a), .rd_busy_b(rd_busy_b), .rd_tag_a(rd_tag_a),
    .rd_tag_b(rd_tag_b), .rename_we(rename_we), .rename_reg(rename_reg), .rename_tag(rename_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .fu_valid(fu_valid),
    .fu_ready(fu_ready), .fu_opcode(fu_opcode), .fu_a(fu_a), .fu_b(fu_b), .fu_imm(fu_imm), .fu_tag(fu_tag));

  always #5 clock = ~clock;

  // reference model: a table of Tomasulo entries plus the dispatch slot
  bit            m_busy[N], m_iss[N];
  logic [2:0]    m_op[N];
  logic [DW-1:0] m_vj[N], m_vk[N];
  logic [TW-1:0] m_qj[N], m_qk[N];
  logic [3:0]    m_imm[N];
  int            m_age[N];
  bit            m_fv;
  logic [2:0]    m_fop;
  logic [DW-1:0] m_fa, m_fb;
  logic [3:0]    m_fimm;
  logic [TW-1:0] m_ftag;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 0; m_iss[i] = 0; m_age[i] = 0;
    end
    m_fv = 0; m_fop = 0; m_fa = 0; m_fb = 0; m_fimm = 0; m_ftag = 0;
  endtask

  function automatic int m_free_slot();
    for (int i = 0; i < N; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic void capture(input logic bsy, input logic [TW-1:0] tg, input logic [DW-1:0] dt,
                                  output logic [DW-1:0] v, output logic [TW-1:0] q);
    if (!bsy) begin v = dt; q = 0; end
    else if (cdb_valid && cdb_tag != 0 && cdb_tag == tg) begin v = cdb_data; q = 0; end
    else begin v = 0; q = tg; end
  endfunction

  // advance the model by one clock edge using the inputs currently driven
  task automatic model_step();
    int slot, pick;
    bit acc;
    slot = m_free_slot();
    acc  = (slot >= 0) && (opcode <= 3'd3);
    pick = -1;
    for (int i = 0; i < N; i++)
      if (m_busy[i] && !m_iss[i] && m_qj[i] == 0 && m_qk[i] == 0)
        if (pick < 0 || (OLDEST && m_age[i] > m_age[pick])) pick = i;
    if (!m_fv || fu_ready) begin
      m_fv = (pick >= 0);
      if (pick >= 0) begin
        m_fop = m_op[pick]; m_fa = m_vj[pick]; m_fb = m_vk[pick]; m_fimm = m_imm[pick];
        m_ftag = TW'(pick + 1); m_iss[pick] = 1;
      end
    end
    for (int i = 0; i < N; i++)
      if (acc && m_busy[i] && m_age[i] < 7) m_age[i]++;
    if (cdb_valid && cdb_tag != 0)
      for (int i = 0; i < N; i++)
        if (m_busy[i]) begin
          if (m_qj[i] == cdb_tag) begin m_vj[i] = cdb_data; m_qj[i] = 0; end
          if (m_qk[i] == cdb_tag) begin m_vk[i] = cdb_data; m_qk[i] = 0; end
          if (cdb_tag == TW'(i + 1)) m_busy[i] = 0;
        end
    if (acc) begin
      m_busy[slot] = 1; m_iss[slot] = 0; m_age[slot] = 0;
      m_op[slot] = opcode; m_imm[slot] = immediate;
      capture(rd_busy_a, rd_tag_a, rd_data_a, m_vj[slot], m_qj[slot]);
      if (opcode == 3'd2) begin m_vk[slot] = 0; m_qk[slot] = 0; end
      else capture(rd_busy_b, rd_tag_b, rd_data_b, m_vk[slot], m_qk[slot]);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_idle();
    opcode = 3'd7; RX = 0; RY = 0; RZ = 0; immediate = 0;
    rd_busy_a = 0; rd_busy_b = 0; rd_tag_a = 0; rd_tag_b = 0; rd_data_a = 0; rd_data_b = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
  endtask

  task automatic do_reset();
    reset = 1; set_idle(); model_reset();
    @(posedge clock); #1;
    reset = 0; #1;
  endtask

  task automatic test_reset();
    reset = 1; set_idle(); opcode = 3'd0; fu_ready = 1; model_reset();
    #2;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall); end
    checks++; if (fu_valid !== 1'b0) begin failures++; $display("FAIL reset_fu_valid got=%0b exp=0", fu_valid); end
    checks++; if ({fu_opcode, fu_a, fu_b, fu_imm, fu_tag} !== '0)
      begin failures++; $display("FAIL reset_fu_fields got=%0h exp=0", {fu_opcode, fu_a, fu_b, fu_imm, fu_tag}); end
    checks++; if (rename_we !== 1'b0) begin failures++; $display("FAIL reset_rename_we got=%0b exp=0", rename_we); end
    @(posedge clock); #1;
    reset = 0; set_idle(); #1;
  endtask

  task automatic test_add();
    do_reset(); fu_ready = 1;
    opcode = 3'd0; RX = 0; RY = 1; RZ = 2; rd_data_a = 5; rd_data_b = 7;
    #1;
    checks++; if (rename_we !== 1'b1) begin failures++; $display("FAIL add_rename_we got=%0b exp=1", rename_we); end
    checks++; if (rename_tag !== 2'd1) begin failures++; $display("FAIL add_rename_tag got=%0d exp=1", rename_tag); end
    checks++; if ({rd_addr_a, rd_addr_b, rename_reg} !== {3'd1, 3'd2, 3'd0})
      begin failures++; $display("FAIL add_addrs got=%0h exp=%0h", {rd_addr_a, rd_addr_b, rename_reg}, {3'd1, 3'd2, 3'd0}); end
    tick(); set_idle();
    checks++; if (fu_valid !== 1'b0) begin failures++; $display("FAIL add_early_valid got=%0b exp=0", fu_valid); end
    tick();
    checks++; if ({fu_valid, fu_opcode, fu_a, fu_b, fu_tag} !== {1'b1, 3'd0, 16'd5, 16'd7, 2'd1})
      begin failures++; $display("FAIL add_dispatch got=%0h exp=%0h", {fu_valid, fu_opcode, fu_a, fu_b, fu_tag},
                                 {1'b1, 3'd0, 16'd5, 16'd7, 2'd1}); end
  endtask

  task automatic test_full_stall();
    do_reset(); fu_ready = 0;
    for (int k = 0; k < 3; k++) begin
      opcode = 3'd0; RX = 3'(k + 1); rd_data_a = 16'(k); rd_data_b = 16'(k + 10);
      tick();
    end
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL full_stall got=%0b exp=1", stall); end
    opcode = 3'd1; RX = 5;
    #1;
    checks++; if (rename_we !== 1'b0) begin failures++; $display("FAIL full_held_we got=%0b exp=0", rename_we); end
    tick();
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL full_still_stall got=%0b exp=1", stall); end
    cdb_valid = 1; cdb_tag = 1; cdb_data = 16'h1111;
    tick(); cdb_valid = 0; #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL free_stall got=%0b exp=0", stall); end
    checks++; if ({rename_we, rename_tag} !== {1'b1, 2'd1})
      begin failures++; $display("FAIL free_reuse got=%0h exp=%0h", {rename_we, rename_tag}, {1'b1, 2'd1}); end
    tick(); set_idle();
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL refill_stall got=%0b exp=1", stall); end
  endtask

  task automatic test_cdb_wakeup();
    do_reset(); fu_ready = 1;
    opcode = 3'd1; rd_busy_a = 1; rd_tag_a = 2; rd_data_b = 3;
    tick(); set_idle(); tick();
    checks++; if (fu_valid !== 1'b0) begin failures++; $display("FAIL wake_wait got=%0b exp=0", fu_valid); end
    cdb_valid = 1; cdb_tag = 2; cdb_data = 16'h00AA;
    tick(); set_idle();
    checks++; if (fu_valid !== 1'b0) begin failures++; $display("FAIL wake_capture_cycle got=%0b exp=0", fu_valid); end
    tick();
    checks++; if ({fu_valid, fu_opcode, fu_a, fu_b, fu_tag} !== {1'b1, 3'd1, 16'h00AA, 16'd3, 2'd1})
      begin failures++; $display("FAIL wake_dispatch got=%0h exp=%0h", {fu_valid, fu_opcode, fu_a, fu_b, fu_tag},
                                 {1'b1, 3'd1, 16'h00AA, 16'd3, 2'd1}); end
  endtask

  task automatic test_bypass();
    do_reset(); fu_ready = 1;
    opcode = 3'd0; rd_data_a = 4; rd_busy_b = 1; rd_tag_b = 3;
    cdb_valid = 1; cdb_tag = 3; cdb_data = 9;
    tick(); set_idle(); tick();
    checks++; if ({fu_valid, fu_a, fu_b} !== {1'b1, 16'd4, 16'd9})
      begin failures++; $display("FAIL bypass got=%0h exp=%0h", {fu_valid, fu_a, fu_b}, {1'b1, 16'd4, 16'd9}); end
  endtask

  task automatic test_sd_reserved();
    do_reset(); fu_ready = 1;
    opcode = 3'd5; RX = 6;
    #1;
    checks++; if (rename_we !== 1'b0) begin failures++; $display("FAIL reserved_we got=%0b exp=0", rename_we); end
    tick(); set_idle(); tick();
    checks++; if (fu_valid !== 1'b0) begin failures++; $display("FAIL reserved_dispatch got=%0b exp=0", fu_valid); end
    opcode = 3'd3; RX = 4; RY = 2; RZ = 6; immediate = 4'hC; rd_data_a = 16'h0100; rd_data_b = 16'hBEEF;
    #1;
    checks++; if ({rename_we, rd_addr_b} !== {1'b0, 3'd4})
      begin failures++; $display("FAIL sd_decode got=%0h exp=%0h", {rename_we, rd_addr_b}, {1'b0, 3'd4}); end
    tick(); set_idle(); tick();
    checks++; if ({fu_valid, fu_opcode, fu_a, fu_b, fu_imm} !== {1'b1, 3'd3, 16'h0100, 16'hBEEF, 4'hC})
      begin failures++; $display("FAIL sd_dispatch got=%0h exp=%0h", {fu_valid, fu_opcode, fu_a, fu_b, fu_imm},
                                 {1'b1, 3'd3, 16'h0100, 16'hBEEF, 4'hC}); end
  endtask

  task automatic test_oldest_first();
    logic [TW-1:0] first_tag, second_tag;
    first_tag  = OLDEST ? 2'd2 : 2'd1;
    second_tag = OLDEST ? 2'd1 : 2'd2;
    do_reset(); fu_ready = 1;
    opcode = 3'd0; rd_busy_a = 1; rd_tag_a = 3; rd_data_b = 1;
    tick(); tick();
    set_idle(); cdb_valid = 1; cdb_tag = 1;
    tick(); set_idle();
    opcode = 3'd0; rd_busy_a = 1; rd_tag_a = 3; rd_data_b = 2;
    #1;
    checks++; if (rename_tag !== 2'd1) begin failures++; $display("FAIL age_refill_tag got=%0d exp=1", rename_tag); end
    tick(); set_idle();
    cdb_valid = 1; cdb_tag = 3; cdb_data = 16'h0033;
    tick(); set_idle(); tick();
    checks++; if ({fu_valid, fu_tag, fu_a} !== {1'b1, first_tag, 16'h0033})
      begin failures++; $display("FAIL age_first got=%0h exp=%0h", {fu_valid, fu_tag, fu_a}, {1'b1, first_tag, 16'h0033}); end
    tick();
    checks++; if ({fu_valid, fu_tag} !== {1'b1, second_tag})
      begin failures++; $display("FAIL age_second got=%0h exp=%0h", {fu_valid, fu_tag}, {1'b1, second_tag}); end
  endtask

  task automatic test_hold_reset();
    do_reset(); fu_ready = 0;
    opcode = 3'd2; RY = 3; immediate = 4'hA; rd_data_a = 16'h1234; rd_busy_b = 1; rd_tag_b = 2;
    tick(); set_idle();
    opcode = 3'd0; rd_data_a = 1; rd_data_b = 2;
    tick(); tick(); set_idle();
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL hold_full got=%0b exp=1", stall); end
    for (int k = 0; k < 3; k++) begin
      checks++; if ({fu_valid, fu_opcode, fu_a, fu_b, fu_imm, fu_tag} !== {1'b1, 3'd2, 16'h1234, 16'd0, 4'hA, 2'd1})
        begin failures++; $display("FAIL hold_cycle%0d got=%0h exp=%0h", k, {fu_valid, fu_opcode, fu_a, fu_b, fu_imm, fu_tag},
                                   {1'b1, 3'd2, 16'h1234, 16'd0, 4'hA, 2'd1}); end
      tick();
    end
    #2; reset = 1; #1;
    checks++; if ({fu_valid, stall} !== 2'b00) begin failures++; $display("FAIL async_reset got=%0b exp=00", {fu_valid, stall}); end
    checks++; if ({fu_opcode, fu_a, fu_imm, fu_tag} !== '0)
      begin failures++; $display("FAIL async_reset_fields got=%0h exp=0", {fu_opcode, fu_a, fu_imm, fu_tag}); end
    @(posedge clock); #1;
    reset = 0; model_reset(); #1;
  endtask

  task automatic test_random();
    int busy_tags[$], iss_tags[$];
    int r, slot;
    bit exp_we;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      busy_tags.delete(); iss_tags.delete();
      for (int i = 0; i < N; i++) if (m_busy[i]) begin
        busy_tags.push_back(i + 1);
        if (m_iss[i]) iss_tags.push_back(i + 1);
      end
      r = $urandom_range(0, 9);
      opcode = (r < 8) ? 3'(r % 4) : ((r == 8) ? 3'd7 : 3'd5);
      RX = 3'($urandom); RY = 3'($urandom); RZ = 3'($urandom); immediate = 4'($urandom);
      rd_data_a = 16'($urandom); rd_data_b = 16'($urandom);
      rd_busy_a = (busy_tags.size() > 0) && ($urandom_range(0, 2) == 0);
      rd_busy_b = (busy_tags.size() > 0) && ($urandom_range(0, 2) == 0);
      rd_tag_a = rd_busy_a ? TW'(busy_tags[$urandom_range(0, busy_tags.size() - 1)]) : TW'($urandom);
      rd_tag_b = rd_busy_b ? TW'(busy_tags[$urandom_range(0, busy_tags.size() - 1)]) : TW'($urandom);
      cdb_data = 16'($urandom);
      if (iss_tags.size() > 0 && $urandom_range(0, 1) == 1) begin
        cdb_valid = 1; cdb_tag = TW'(iss_tags[$urandom_range(0, iss_tags.size() - 1)]);
      end else begin
        cdb_valid = ($urandom_range(0, 7) == 0); cdb_tag = 0;
      end
      fu_ready = ($urandom_range(0, 3) != 0);
      #1;
      slot = m_free_slot();
      exp_we = (slot >= 0) && (opcode <= 3'd2);
      checks++; if (stall !== (slot < 0)) begin failures++; $display("FAIL rnd%0d_stall got=%0b exp=%0b", c, stall, slot < 0); end
      checks++; if (rename_we !== exp_we) begin failures++; $display("FAIL rnd%0d_rename_we got=%0b exp=%0b", c, rename_we, exp_we); end
      if (exp_we) begin
        checks++; if (rename_tag !== TW'(slot + 1))
          begin failures++; $display("FAIL rnd%0d_rename_tag got=%0d exp=%0d", c, rename_tag, slot + 1); end
      end
      tick();
      checks++; if (fu_valid !== m_fv) begin failures++; $display("FAIL rnd%0d_fu_valid got=%0b exp=%0b", c, fu_valid, m_fv); end
      if (m_fv) begin
        checks++; if ({fu_opcode, fu_a, fu_b, fu_imm, fu_tag} !== {m_fop, m_fa, m_fb, m_fimm, m_ftag})
          begin failures++; $display("FAIL rnd%0d_fu_fields got=%0h exp=%0h", c, {fu_opcode, fu_a, fu_b, fu_imm, fu_tag},
                                     {m_fop, m_fa, m_fb, m_fimm, m_ftag}); end
      end
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_add();
    test_full_stall();
    test_cdb_wakeup();
    test_bypass();
    test_sd_reserved();
    test_oldest_first();
    test_hold_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
